dmem_ctrl: RTL and testbench

- Parametrised data memory for the RV32 core's load/store path; replaces the fixed 256-word combinational data RAM.
- Adds a valid/ready request channel and a valid/ready response channel with configurable wait states.
- Adds per-byte-lane writes, load sign/zero extension, and error reporting for misaligned, illegal-size and out-of-range accesses.
- Sits between the core's memory stage and the word-organised storage array. Only one transaction is outstanding at a time.

---
 rtl/dmem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Word-organised data memory behind valid/ready request and response channels.
// Handles byte-lane stores, load extension, error flagging and programmable wait states.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic             we_q, uns_q, err_q;
  logic [1:0]       size_q, off_q;
  logic [IDX_W-1:0] idx_q;

  logic              accept, enter_resp;
  logic [ADDR_W-1:0] addr_hi;
  logic              err_in, misalign_in;
  logic [IDX_W-1:0]  idx_in;
  logic [3:0]        lane_en;
  logic [31:0]       wdata_sh;

  logic             cur_we, cur_uns, cur_err;
  logic [1:0]       cur_size, cur_off;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      load_word, load_sh, load_val;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;

  // Every address bit above the word index must be zero: no aliasing into the array.
  assign addr_hi = req_addr >> (IDX_W + 2);
  assign idx_in  = req_addr[IDX_W+1:2];

  always_comb begin
    misalign_in = 1'b0;
    case (req_size)
      2'b01:   misalign_in = req_addr[0];
      2'b10:   misalign_in = |req_addr[1:0];
      2'b11:   misalign_in = 1'b1;
      default: misalign_in = 1'b0;
    endcase
  end

  assign err_in = misalign_in || (|addr_hi);

  always_comb begin
    lane_en = 4'b0000;
    case (req_size)
      2'b00:   lane_en = 4'b0001 << req_addr[1:0];
      2'b01:   lane_en = req_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign wdata_sh = req_wdata << {req_addr[1:0], 3'b000};

  // Stores commit on the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && !err_in) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[idx_in][8*k +: 8] <= wdata_sh[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nxt   = '0;
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == LAST_WAIT) state_nxt = RESP;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // With no wait states the response is formed on the accepting edge, straight from the inputs.
  assign cur_we   = (state == IDLE) ? req_we       : we_q;
  assign cur_uns  = (state == IDLE) ? req_unsigned : uns_q;
  assign cur_err  = (state == IDLE) ? err_in       : err_q;
  assign cur_size = (state == IDLE) ? req_size     : size_q;
  assign cur_off  = (state == IDLE) ? req_addr[1:0] : off_q;
  assign cur_idx  = (state == IDLE) ? idx_in       : idx_q;

  assign load_word = mem[cur_idx];
  assign load_sh   = load_word >> {cur_off, 3'b000};

  always_comb begin
    load_val = load_word;
    case (cur_size)
      2'b00:   load_val = cur_uns ? {24'h0, load_sh[7:0]}  : {{24{load_sh[7]}}, load_sh[7:0]};
      2'b01:   load_val = cur_uns ? {16'h0, load_sh[15:0]} : {{16{load_sh[15]}}, load_sh[15:0]};
      default: load_val = load_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      idx_q     <= '0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        err_q  <= err_in;
        size_q <= req_size;
        off_q  <= req_addr[1:0];
        idx_q  <= idx_in;
      end
      if (enter_resp) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_err || cur_we) ? 32'h0 : load_val;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: zero-wait and three-wait-state instances against a byte-level memory model.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst3_n, sel;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rv0, rv3, rr0, rr3;
  logic        req_ready0, rsp_valid0, rsp_err0, req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata0, rsp_rdata3;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  assign rv0 = req_valid & ~sel;
  assign rv3 = req_valid &  sel;
  assign rr0 = rsp_ready & ~sel;
  assign rr3 = rsp_ready &  sel;
  assign o_req_ready = sel ? req_ready3 : req_ready0;
  assign o_rsp_valid = sel ? rsp_valid3 : rsp_valid0;
  assign o_rsp_err   = sel ? rsp_err3   : rsp_err0;
  assign o_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata0;

  dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .req_valid(rv0), .req_ready(req_ready0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rr0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(rv3), .req_ready(req_ready3), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rr3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

  int checks = 0;
  int fails  = 0;

  logic [31:0] refm [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes; a transfer of n bytes touches bytes off..off+n-1 of one word.
  function automatic void model(input int d, input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output bit e);
    int n, off, widx;
    logic [31:0] v;
    rd = 32'h0;
    e  = (size == 2'b11);
    n  = 1 << size;
    if (!e && (addr % n) != 0) e = 1'b1;
    if (addr / 4 >= 256) e = 1'b1;
    if (e) return;
    widx = int'(addr / 4);
    off  = int'(addr % 4);
    if (we) begin
      for (int i = 0; i < n; i++) refm[d][widx][8*(off+i) +: 8] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refm[d][widx][8*(off+i) +: 8];
      if (!uns && n < 4 && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  task automatic txn(input bit d3, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     input logic [31:0] exp_rd, input bit exp_e);
    int lat;
    bit got;
    @(negedge clk);
    sel = d3; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1; rsp_ready = 1'b0;
    chk("req_ready_idle", o_req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom; req_size = 2'($urandom); req_unsigned = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (o_rsp_valid) got = 1'b1;
      else chk("req_ready_busy", o_req_ready, 0);
    end
    chk("latency", lat, d3 ? 4 : 1);
    chk("rdata", o_rsp_rdata, exp_rd);
    chk("err", o_rsp_err, exp_e);
    chk("req_ready_resp", o_req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_rdata", o_rsp_rdata, exp_rd);
      chk("hold_err", o_rsp_err, exp_e);
      chk("hold_req_ready", o_req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", o_rsp_valid, 0);
    chk("post_req_ready", o_req_ready, 1);
  endtask

  task automatic run(input bit d3, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] rd;
    bit e;
    model(int'(d3), we, size, uns, addr, wdata, rd, e);
    txn(d3, we, size, uns, addr, wdata, hold, rd, e);
  endtask

  task automatic directed(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_e);
    logic [31:0] rd;
    bit e;
    model(0, we, size, uns, addr, wdata, rd, e);
    txn(1'b0, we, size, uns, addr, wdata, 0, exp_rd, exp_e);
  endtask

  task automatic abort_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    bit e;
    model(1, we, 2'b10, 1'b0, addr, wdata, rd, e);
    @(negedge clk);
    sel = 1'b1; req_we = we; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", rsp_valid3, 0);
    #1;
    rst3_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready3, 1);
    chk("abort_rsp_valid", rsp_valid3, 0);
    chk("abort_rdata", rsp_rdata3, 0);
    chk("abort_err", rsp_err3, 0);
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid3, 0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    rst0_n = 1'b0; rst3_n = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    @(negedge clk);
    chk("rst_req_ready0", req_ready0, 1);
    chk("rst_rsp_valid0", rsp_valid0, 0);
    chk("rst_rdata0", rsp_rdata0, 0);
    chk("rst_err0", rsp_err0, 0);
    chk("rst_req_ready3", req_ready3, 1);
    chk("rst_rsp_valid3", rsp_valid3, 0);
    chk("rst_rdata3", rsp_rdata3, 0);
    chk("rst_err3", rsp_err3, 0);
    @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        run(d[0], 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0);

    directed(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    directed(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    directed(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    directed(1'b1, 2'b00, 1'b0, 32'h21, 32'hABCDEF80, 32'h0, 1'b0);
    directed(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555F00D, 32'h0, 1'b0);
    directed(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hF00D8000, 1'b0);
    directed(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
    directed(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0);
    directed(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFFF00D, 1'b0);
    directed(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000F00D, 1'b0);
    directed(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    directed(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234, 32'h0, 1'b1);
    directed(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    directed(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    directed(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 32'h0, 1'b1);
    directed(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0, 32'h0, 1'b1);

    run(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 0);
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5, 32'hCAFEF00D, 1'b0);

    for (int i = 0; i < 80; i++) begin
      sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      case ($urandom % 10)
        0:       ad = 32'd1024 + ($urandom % 4096);
        1:       ad = $urandom | 32'h80000000;
        default: ad = (($urandom % 16) * 4) + ($urandom % 4);
      endcase
      run(1'($urandom), 1'($urandom), sz, 1'($urandom), ad, $urandom, int'($urandom % 3));
    end

    abort_txn(1'b1, 32'h34, 32'h2468ACE0);
    abort_txn(1'b0, 32'h30, 32'h0);
    run(1'b1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 0);
    chk("store_survives_reset", refm[1][13], 32'h2468ACE0);
    run(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
